if_id_queue: RTL and testbench



---
 rtl/if_id_queue_pkg.sv | 34 +++
 rtl/if_id_queue_ir_decode.sv | 48 ++++
 rtl/if_id_queue.sv | 130 +++++++++++++
 tb/tb_if_id_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// RV32I shared types: opcodes, prediction/RVFI sidebands and the fetch-to-decode queue entry.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_pred_sigs;

  typedef struct packed {
    logic [31:0] order;
    logic [31:0] insn;
  } rvfi_sigs;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    br_pred_sigs br_pred;
    rvfi_sigs    rvfi;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_ir_decode.sv
// Combinational RV32I field decoder; register indices an opcode does not use are forced to zero.
module ir_decode
  import rv32i_types::*;
(
  input  logic [31:0] instr_i,
  output rv32i_opcode opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [31:0] i_imm_o,
  output logic [31:0] s_imm_o,
  output logic [31:0] b_imm_o,
  output logic [31:0] u_imm_o,
  output logic [31:0] j_imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o
);

  rv32i_opcode w_opcode;

  assign w_opcode = rv32i_opcode'(instr_i[6:0]);
  assign opcode_o = w_opcode;
  assign funct3_o = instr_i[14:12];
  assign funct7_o = instr_i[31:25];

  assign i_imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
  assign s_imm_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
  assign b_imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign u_imm_o = {instr_i[31:12], 12'h000};
  assign j_imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Register index selection with per-opcode zeroing
  always_comb begin
    rs1_o = instr_i[19:15];
    rs2_o = instr_i[24:20];
    rd_o  = instr_i[11:7];
    case (w_opcode)
      op_lui, op_auipc, op_jal: begin
        rs1_o = 5'd0;
        rs2_o = 5'd0;
      end
      op_imm, op_load, op_jalr: rs2_o = 5'd0;
      op_br, op_store:          rd_o  = 5'd0;
      default:                  rd_o  = instr_i[11:7];
    endcase
  end

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode circular instruction queue with head-entry decode and single-cycle flush.
// Optional empty-queue bypass from fetch to decode: define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       instr_i,
  input  br_pred_sigs       br_pred_i,
  input  rvfi_sigs          rvfi_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       pc_o,
  output rv32i_opcode       opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       i_imm_o,
  output logic [31:0]       s_imm_o,
  output logic [31:0]       b_imm_o,
  output logic [31:0]       u_imm_o,
  output logic [31:0]       j_imm_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output br_pred_sigs       br_pred_o,
  output rvfi_sigs          rvfi_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  if_id_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  if_id_entry_t w_in_entry;
  if_id_entry_t w_head;
  logic         w_empty;
  logic         w_full;
  logic         w_push;
  logic         w_pop;
  logic         w_bypass;

  assign w_in_entry = '{pc: pc_i, instr: instr_i, br_pred: br_pred_i, rvfi: rvfi_i};
  assign w_empty    = (r_count == {CNT_W{1'b0}});
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign in_ready   = !w_full;
  assign count_o    = r_count;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign w_bypass  = w_empty && in_valid && !flush;
  assign out_valid = !w_empty || w_bypass;
  // A bypassed instruction consumed the same cycle never occupies a slot
  assign w_push    = in_valid && in_ready && !(w_bypass && out_ready);
  assign w_pop     = !w_empty && out_ready;
`else
  assign w_bypass  = 1'b0;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
`endif

  // Head entry selection: stored head, bypassed input, or an all-zero entry when empty
  always_comb begin
    if (w_bypass) begin
      w_head = w_in_entry;
    end else if (!w_empty) begin
      w_head = r_mem[r_head];
    end else begin
      w_head = '0;
    end
  end

  // Pointer, occupancy and storage update; flush discards everything incl. this cycle's push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_in_entry;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign pc_o      = w_head.pc;
  assign br_pred_o = w_head.br_pred;
  assign rvfi_o    = w_head.rvfi;

  ir_decode u_ir_decode (
    .instr_i  (w_head.instr),
    .opcode_o (opcode_o),
    .funct3_o (funct3_o),
    .funct7_o (funct7_o),
    .i_imm_o  (i_imm_o),
    .s_imm_o  (s_imm_o),
    .b_imm_o  (b_imm_o),
    .u_imm_o  (u_imm_o),
    .j_imm_o  (j_imm_o),
    .rs1_o    (rs1_o),
    .rs2_o    (rs2_o),
    .rd_o     (rd_o)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (default build): directed cases plus random traffic vs a queue model.
module tb_if_id_queue;
  import rv32i_types::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      pc_i, instr_i, pc_o;
  br_pred_sigs      br_pred_i, br_pred_o;
  rvfi_sigs         rvfi_i, rvfi_o;
  rv32i_opcode      opcode_o;
  logic [2:0]       funct3_o;
  logic [6:0]       funct7_o;
  logic [31:0]      i_imm_o, s_imm_o, b_imm_o, u_imm_o, j_imm_o;
  logic [4:0]       rs1_o, rs2_o, rd_o;
  logic [CNT_W-1:0] count_o;

  int n_cmp = 0;
  int n_err = 0;
  if_id_entry_t mq[$];

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .instr_i(instr_i), .br_pred_i(br_pred_i), .rvfi_i(rvfi_i),
    .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o), .opcode_o(opcode_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .i_imm_o(i_imm_o), .s_imm_o(s_imm_o),
    .b_imm_o(b_imm_o), .u_imm_o(u_imm_o), .j_imm_o(j_imm_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .rd_o(rd_o), .br_pred_o(br_pred_o), .rvfi_o(rvfi_o), .count_o(count_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sign-extend the low 'bits' bits of v using arithmetic on integers
  function automatic logic [31:0] sext(input longint v, input int bits);
    longint r;
    r = v;
    if (((v >> (bits - 1)) & 1) != 0) r = v - (longint'(1) << bits);
    return 32'(r);
  endfunction

  // Compare every DUT output with what the model's head entry implies
  task automatic check_all();
    if_id_entry_t e;
    longint       ins;
    logic [6:0]   op;
    logic [4:0]   e_rs1, e_rs2, e_rd;
    e     = (mq.size() != 0) ? mq[0] : '0;
    ins   = longint'(e.instr);
    op    = e.instr[6:0];
    e_rs1 = (op == 7'h37 || op == 7'h17 || op == 7'h6F) ? 5'd0 : 5'((ins >> 15) & 31);
    e_rs2 = (op inside {7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) ? 5'd0 : 5'((ins >> 20) & 31);
    e_rd  = (op == 7'h63 || op == 7'h23) ? 5'd0 : 5'((ins >> 7) & 31);
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check_eq("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    check_eq("count_o",   64'(count_o),   64'(mq.size()));
    check_eq("pc_o",      64'(pc_o),      64'(e.pc));
    check_eq("br_pred_o", 64'(br_pred_o), 64'(e.br_pred));
    check_eq("rvfi_o",    64'(rvfi_o),    64'(e.rvfi));
    check_eq("opcode_o",  64'(opcode_o),  64'(op));
    check_eq("funct3_o",  64'(funct3_o),  64'((ins >> 12) & 7));
    check_eq("funct7_o",  64'(funct7_o),  64'((ins >> 25) & 127));
    check_eq("i_imm_o",   64'(i_imm_o),   64'(sext(ins >> 20, 12)));
    check_eq("s_imm_o",   64'(s_imm_o),   64'(sext(((ins >> 25) << 5) | ((ins >> 7) & 31), 12)));
    check_eq("b_imm_o",   64'(b_imm_o),   64'(sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
                                           | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13)));
    check_eq("u_imm_o",   64'(u_imm_o),   64'(ins & 64'hFFFF_F000));
    check_eq("j_imm_o",   64'(j_imm_o),   64'(sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12)
                                           | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21)));
    check_eq("rs1_o",     64'(rs1_o),     64'(e_rs1));
    check_eq("rs2_o",     64'(rs2_o),     64'(e_rs2));
    check_eq("rd_o",      64'(rd_o),      64'(e_rd));
  endtask

  // One clock: drive inputs at the falling edge, check, then advance the model at the rising edge
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic rs);
    if_id_entry_t e;
    logic         do_push, do_pop;
    in_valid  = v;
    pc_i      = pc;
    instr_i   = ins;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    br_pred_i = '{taken: 1'($urandom), target: $urandom};
    rvfi_i    = '{order: $urandom, insn: $urandom};
    #1;
    check_all();
    e = '{pc: pc, instr: ins, br_pred: br_pred_i, rvfi: rvfi_i};
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
    end else begin
      do_push = v && (mq.size() < DEPTH);
      do_pop  = (mq.size() != 0) && ordy;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_i = 32'd0; instr_i = 32'd0; br_pred_i = '0; rvfi_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, then ADDI x5,x1,12 visible one cycle after push
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);
    check_eq("rst_count",     64'(count_o),   64'd0);
    check_eq("rst_pc",        64'(pc_o),      64'd0);
    @(negedge clk);
    step(1'b1, 32'h60, 32'h00C0_8293, 1'b0, 1'b0, 1'b0);
    check_eq("addi_valid", 64'(out_valid), 64'd1);
    check_eq("addi_rs1",   64'(rs1_o),     64'd1);
    check_eq("addi_rs2",   64'(rs2_o),     64'd0);
    check_eq("addi_rd",    64'(rd_o),      64'd5);
    check_eq("addi_imm",   64'(i_imm_o),   64'd12);
    check_eq("addi_pc",    64'(pc_o),      64'h60);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("pop_empty", 64'(out_valid), 64'd0);

    // Fill to DEPTH, overflow push ignored, push+pop at full rejected
    for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    check_eq("full_count", 64'(count_o),  64'd4);
    check_eq("full_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h10, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_count", 64'(count_o), 64'd4);
    check_eq("ovf_head",  64'(pc_o),    64'h0);
    step(1'b1, 32'h14, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
    check_eq("fullpp_count", 64'(count_o), 64'd3);
    check_eq("fullpp_head",  64'(pc_o),    64'h4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("order_8", 64'(pc_o), 64'h8);
    step(1'b1, 32'h18, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
    check_eq("pp2_count", 64'(count_o), 64'd2);
    check_eq("order_c",   64'(pc_o),    64'hC);

    // Flush at count 3 with a concurrent push
    step(1'b1, 32'h1C, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    check_eq("pre_flush", 64'(count_o), 64'd3);
    step(1'b1, 32'h20, 32'h0000_0013, 1'b1, 1'b1, 1'b0);
    check_eq("flush_count", 64'(count_o),   64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);

    // Decoder boundary cases: BEQ negative offset, SW, LUI
    step(1'b1, 32'h100, 32'hFE00_0EE3, 1'b0, 1'b0, 1'b0);
    check_eq("beq_rd",   64'(rd_o),    64'd0);
    check_eq("beq_bimm", 64'(b_imm_o), 64'hFFFF_FFFC);
    step(1'b1, 32'h104, 32'h0050_A423, 1'b1, 1'b0, 1'b0);
    check_eq("sw_rd",   64'(rd_o),    64'd0);
    check_eq("sw_simm", 64'(s_imm_o), 64'd8);
    step(1'b1, 32'h108, 32'h1234_53B7, 1'b1, 1'b0, 1'b0);
    check_eq("lui_rs1",  64'(rs1_o),   64'd0);
    check_eq("lui_rs2",  64'(rs2_o),   64'd0);
    check_eq("lui_rd",   64'(rd_o),    64'd7);
    check_eq("lui_uimm", 64'(u_imm_o), 64'h1234_5000);

    // Random traffic, occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(9, 0)];
      step(1'($urandom_range(99, 0) < 60), $urandom, ins, 1'($urandom_range(99, 0) < 45),
           1'($urandom_range(99, 0) < 4), 1'($urandom_range(99, 0) < 1));
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
